// File: rtl/vlc_ofdm_pkg.sv
// vlc_ofdm_pkg
// Shared burst geometry for the VLC OFDM link (transmit framer and receiver
// time-sync / CP-removal logic) plus the framer read-FSM state encoding.
//   FFT_POINT     samples per symbol body
//   CP_NUM        cyclic-prefix length (<= FFT_POINT)
//   PREAMB_SYM    preamble symbols per burst
//   DATA_SYM      data symbols per burst
//   BURST_SAMPLES total framed samples per burst (1120 with defaults)
package vlc_ofdm_pkg;

    localparam int FFT_POINT     = 64;
    localparam int CP_NUM        = 16;
    localparam int PREAMB_SYM    = 6;
    localparam int DATA_SYM      = 8;
    localparam int BURST_SYM     = PREAMB_SYM + DATA_SYM;
    localparam int SYM_SAMPLES   = FFT_POINT + CP_NUM;
    localparam int BURST_SAMPLES = BURST_SYM * SYM_SAMPLES;

    // state   | meaning
    // IDLE    | no burst, waiting for start
    // WAIT    | waiting for the current read bank to be full
    // CP      | emitting the cyclic prefix (tail of the bank)
    // BODY    | emitting the full symbol body
    // DONE    | last sample in output register, pulse tx_done once it is taken
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_CP   = 3'd2,
        ST_BODY = 3'd3,
        ST_DONE = 3'd4
    } framer_state_e;

endpackage

// File: rtl/ofdm_pingpong_buf.sv
// ofdm_pingpong_buf
// Two-bank symbol buffer. The write side fills banks in alternating order and
// marks a bank full after its FFT_POINT-th sample; the read side frees a bank
// explicitly. Reads are registered (data appears the cycle after rd_en_i).
// Ports:
//   clk_i, rst_i   clock, async active-high reset (flags and read register only)
//   clr_i          burst start: both banks empty, write pointer to bank 0 idx 0
//   wr_en_i        write wr_data_i at the current write pointer
//   wr_avail_o     current write bank is empty (writer may proceed)
//   wr_last_o      this write completes a bank
//   full_o         per-bank full flags
//   rd_en_i        load rd_data_o from bank rd_bank_i, index rd_idx_i
//   free_en_i      mark bank rd_bank_i empty
//   rd_data_o      registered read data
module ofdm_pingpong_buf #(
    parameter int FFT_POINT = 64,
    parameter int DW        = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          wr_en_i,
    input  logic [DW-1:0]                 wr_data_i,
    output logic                          wr_avail_o,
    output logic                          wr_last_o,
    output logic [1:0]                    full_o,
    input  logic                          rd_en_i,
    input  logic                          rd_bank_i,
    input  logic [$clog2(FFT_POINT)-1:0]  rd_idx_i,
    input  logic                          free_en_i,
    output logic [DW-1:0]                 rd_data_o
);

    localparam int IW = $clog2(FFT_POINT);
    localparam int AW = IW + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(FFT_POINT - 1);

    logic [DW-1:0] mem [2**AW];

    logic          wr_bank_q;
    logic [IW-1:0] wr_idx_q;
    logic [1:0]    full_q;
    logic [DW-1:0] rd_data_q;

    assign wr_avail_o = !full_q[wr_bank_q];
    assign wr_last_o  = wr_en_i && (wr_idx_q == IDX_LAST);
    assign full_o     = full_q;
    assign rd_data_o  = rd_data_q;

    // Sample storage has no reset; contents survive reset and clr.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[{wr_bank_q, wr_idx_q}] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[{rd_bank_i, rd_idx_i}];
        end
    end

    // The writer only ever targets a non-full bank and the reader only frees a
    // full one, so a set and a clear never land on the same flag in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= 2'b00;
        end else if (clr_i) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            if (wr_en_i) begin
                if (wr_idx_q == IDX_LAST) begin
                    full_q[wr_bank_q] <= 1'b1;
                    wr_bank_q         <= ~wr_bank_q;
                    wr_idx_q          <= '0;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end
            if (free_en_i) begin
                full_q[rd_bank_i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ofdm_burst_framer.sv
// ofdm_burst_framer
// Builds one transmit burst of PREAMB_SYM+DATA_SYM OFDM symbols, each emitted as
// its last CP_NUM samples (cyclic prefix) followed by the full FFT_POINT body.
// Input symbols are staged in a ping-pong buffer; the read FSM drains them.
// Ports:
//   clk, rst               clock, async active-high reset
//   start                  one-cycle pulse, honoured only when idle
//   din/din_valid/din_ready  IFFT sample input, natural order
//   dout/dout_valid/dout_ready  framed sample output
//   busy                   burst in progress
//   tx_done                one-cycle pulse after the last burst sample is taken
//   underrun               sticky: a symbol was not buffered when its slot came
module ofdm_burst_framer #(
    parameter int FFT_POINT  = vlc_ofdm_pkg::FFT_POINT,
    parameter int CP_NUM     = vlc_ofdm_pkg::CP_NUM,
    parameter int PREAMB_SYM = vlc_ofdm_pkg::PREAMB_SYM,
    parameter int DATA_SYM   = vlc_ofdm_pkg::DATA_SYM,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          tx_done,
    output logic          underrun
);

    import vlc_ofdm_pkg::*;

    localparam int TOTAL_SYM = PREAMB_SYM + DATA_SYM;
    localparam int IW        = $clog2(FFT_POINT);
    localparam int SW        = $clog2(TOTAL_SYM + 1);

    localparam logic [IW-1:0] IDX_LAST  = IW'(FFT_POINT - 1);
    localparam logic [IW-1:0] IDX_CP    = IW'(FFT_POINT - CP_NUM);
    localparam logic [SW-1:0] SYM_LAST  = SW'(TOTAL_SYM - 1);
    localparam logic [SW-1:0] SYM_TOTAL = SW'(TOTAL_SYM);

    framer_state_e state_q;
    logic [IW-1:0] rd_idx_q;
    logic          rd_bank_q;
    logic [SW-1:0] sym_cnt_q;
    logic [SW-1:0] wr_sym_q;
    logic          dout_valid_q;
    logic          busy_q;
    logic          tx_done_q;
    logic          underrun_q;

    logic          slot_free;
    logic          rd_en;
    logic          free_en;
    logic          clr;
    logic          wr_en;
    logic          wr_last;
    logic          wr_avail;
    logic [1:0]    full;

    // Output register can take a new sample if empty or being drained now;
    // this lets CP->BODY and symbol->symbol run without bubbles.
    assign slot_free = !dout_valid_q || dout_ready;
    assign clr       = (state_q == ST_IDLE) && start;
    assign din_ready = busy_q && wr_avail && (wr_sym_q < SYM_TOTAL);
    assign wr_en     = din_valid && din_ready;

    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign underrun   = underrun_q;

    always_comb begin
        rd_en   = 1'b0;
        free_en = 1'b0;
        if ((state_q == ST_CP || state_q == ST_BODY) && slot_free) begin
            rd_en = 1'b1;
        end
        if (state_q == ST_BODY && slot_free && rd_idx_q == IDX_LAST) begin
            free_en = 1'b1;
        end
    end

    ofdm_pingpong_buf #(
        .FFT_POINT (FFT_POINT),
        .DW        (DW)
    ) u_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .wr_en_i    (wr_en),
        .wr_data_i  (din),
        .wr_avail_o (wr_avail),
        .wr_last_o  (wr_last),
        .full_o     (full),
        .rd_en_i    (rd_en),
        .rd_bank_i  (rd_bank_q),
        .rd_idx_i   (rd_idx_q),
        .free_en_i  (free_en),
        .rd_data_o  (dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_idx_q     <= '0;
            rd_bank_q    <= 1'b0;
            sym_cnt_q    <= '0;
            wr_sym_q     <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;

            if (rd_en) begin
                dout_valid_q <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (wr_last) begin
                wr_sym_q <= wr_sym_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_WAIT;
                        busy_q     <= 1'b1;
                        rd_idx_q   <= '0;
                        rd_bank_q  <= 1'b0;
                        sym_cnt_q  <= '0;
                        wr_sym_q   <= '0;
                        underrun_q <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (full[rd_bank_q]) begin
                        state_q  <= ST_CP;
                        rd_idx_q <= IDX_CP;
                    end else if (sym_cnt_q != '0) begin
                        // The first symbol may legitimately take a while to
                        // arrive; after that an empty bank means a gap on air.
                        underrun_q <= 1'b1;
                    end
                end

                ST_CP: begin
                    if (slot_free) begin
                        if (rd_idx_q == IDX_LAST) begin
                            rd_idx_q <= '0;
                            state_q  <= ST_BODY;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end

                ST_BODY: begin
                    if (slot_free) begin
                        if (rd_idx_q == IDX_LAST) begin
                            rd_idx_q  <= IDX_CP;
                            rd_bank_q <= ~rd_bank_q;
                            sym_cnt_q <= sym_cnt_q + 1'b1;
                            if (sym_cnt_q == SYM_LAST) begin
                                state_q <= ST_DONE;
                            end else if (full[~rd_bank_q]) begin
                                state_q <= ST_CP;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (dout_valid_q && dout_ready) begin
                        tx_done_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_burst_framer.sv
module tb_ofdm_burst_framer;

    import vlc_ofdm_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          tx_done;
    logic          underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    int   n_out;
    int   cyc = 0;
    int   last_acc = -10;
    int   done_cnt = 0;
    bit   done_seen;
    bit   hold_pending = 0;
    logic [DW-1:0] hold_val;
    bit   bp_mode = 0;
    bit   stop_drv = 0;

    always #5 clk = ~clk;

    ofdm_burst_framer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .underrun   (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream acceptance: always ready, or a coin flip per cycle.
    always @(posedge clk) begin
        #1;
        if (bp_mode) dout_ready = ($urandom_range(0, 1) == 1);
        else         dout_ready = 1'b1;
    end

    // Monitor / scoreboard: observes the handshake mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        cyc++;
        if (rst !== 1'b0) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", dout_valid, 1);
                check("hold_data", dout, hold_val);
            end
            hold_pending = dout_valid && !dout_ready;
            hold_val     = dout;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0d, expected no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", dout, e);
                end
                n_out++;
                last_acc = cyc;
            end
            if (tx_done) begin
                check("tx_done_latency", cyc, last_acc + 1);
                done_seen = 1;
                done_cnt++;
            end
        end
    end

    task automatic start_burst();
        n_out     = 0;
        done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic push_symbol(input int s);
        for (int k = FFT_POINT - CP_NUM; k < FFT_POINT; k++) exp_q.push_back(DW'((s * 16 + k) & 255));
        for (int k = 0; k < FFT_POINT; k++)                  exp_q.push_back(DW'((s * 16 + k) & 255));
    endtask

    task automatic drive_burst(input int gap_sym, input bit misuse);
        for (int s = 0; s < BURST_SYM; s++) begin
            for (int i = 0; i < FFT_POINT; i++) begin
                int t = 0;
                if (stop_drv) begin din_valid = 1'b0; return; end
                din       = DW'((s * 16 + i) & 255);
                din_valid = 1'b1;
                if (misuse && s == 5 && i == 10) start = 1'b1;
                while (!din_ready && !stop_drv) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    t++;
                    if (t > 3000) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL din_ready_timeout: got 0 after %0d cycles, expected 1", t);
                        din_valid = 1'b0;
                        return;
                    end
                end
                if (stop_drv) begin din_valid = 1'b0; return; end
                @(posedge clk); #1;
                start = 1'b0;
            end
            din_valid = 1'b0;
            push_symbol(s);
            if (s == gap_sym) begin
                check("underrun_before_gap", underrun, 0);
                repeat (200) @(posedge clk);
                #1;
                check("gap_dout_valid", dout_valid, 0);
                check("underrun_set", underrun, 1);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic finish_burst(input bit exp_underrun);
        int t = 0;
        int d0;
        d0 = done_cnt;
        while (!done_seen && t < 10000) begin
            @(posedge clk); #1;
            t++;
        end
        check("tx_done_seen", done_seen, 1);
        check("tx_done_pulse_width", tx_done, 0);
        check("busy_after_done", busy, 0);
        check("sample_count", n_out, BURST_SAMPLES);
        check("queue_empty", exp_q.size(), 0);
        check("underrun_flag", underrun, exp_underrun);
        repeat (5) @(posedge clk);
        #1;
        check("single_tx_done", done_cnt - d0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic burst, with a mid-burst start pulse and an overfeed attempt.
        start_burst();
        drive_burst(-1, 1'b1);
        din       = 8'hEE;
        din_valid = 1'b1;
        cnt = 0;
        repeat (30) begin
            if (din_ready) cnt++;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        check("overfeed_ready_cycles", cnt, 0);
        finish_burst(1'b0);

        // Random backpressure.
        bp_mode = 1;
        start_burst();
        drive_burst(-1, 1'b0);
        finish_burst(1'b0);
        bp_mode = 0;
        @(posedge clk); #1;

        // Input starvation after symbol 3.
        start_burst();
        drive_burst(3, 1'b0);
        finish_burst(1'b1);

        // Reset in the middle of a burst.
        start_burst();
        fork
            drive_burst(-1, 1'b0);
            begin
                int t = 0;
                while (n_out < 500 && t < 5000) begin
                    @(posedge clk); #1;
                    t++;
                end
                check("reached_500_samples", n_out >= 500, 1);
                stop_drv = 1;
                rst      = 1'b1;
                #1;
                check("midrst_dout", dout, 0);
                check("midrst_dout_valid", dout_valid, 0);
                check("midrst_din_ready", din_ready, 0);
                check("midrst_busy", busy, 0);
                check("midrst_tx_done", tx_done, 0);
                check("midrst_underrun", underrun, 0);
            end
        join
        exp_q.delete();
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b0;
        stop_drv = 0;
        repeat (20) @(posedge clk);
        #1;
        check("no_tx_done_after_reset", done_cnt, d0);
        check("idle_after_reset", busy, 0);

        start_burst();
        drive_burst(-1, 1'b0);
        finish_burst(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
